lsu_axi_wr_sched: RTL
=====================

Name: lsu_axi_wr_sched

Overview:
Store-command sequencer that sits between the LSU store issue logic and the AXI write interface block. It accepts one strided store command and splits it into N INCR bursts. For each burst it issues the address handshake, reads beats from on-chip RAM (ORAM) and streams them on the write-data handshake. It counts outstanding write responses and reports completion and error status back to the LSU.

Parameters:
ADDR_W, 10, AXI byte-address width (all address arithmetic modulo 2^ADDR_W)
DATA_W, 64, beat width; strobe width is DATA_W/8
ORAM_AW, 12, ORAM word-address width (modulo 2^ORAM_AW)
MAX_OUT, 16, maximum AW handshakes awaiting a B response; power of two, at most 16

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
cmd_vld  in  1  command valid
cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy
cmd_addr  in  ADDR_W  byte address of burst 0
cmd_stride  in  3  burst-to-burst address step: 0=16, 1=32, 2=64, 3=128, 4=256; 5-7 treated as 16
cmd_num  in  4  number of bursts minus 1 (1..16 bursts)
cmd_len  in  8  AXI AWLEN: beats per burst minus 1
cmd_oram_addr  in  ORAM_AW  ORAM word holding beat 0 of burst 0
oram_rd_en  out  1  ORAM read strobe
oram_rd_addr  out  ORAM_AW  ORAM read address
oram_rd_data  in  DATA_W  ORAM data, valid exactly 1 cycle after oram_rd_en
aw_vld  out  1  address request to the write interface
aw_rdy  in  1  address accept
aw_addr  out  ADDR_W  burst address
aw_len  out  8  equals latched cmd_len
aw_size  out  3  constant 3'b011 (8 bytes)
aw_burst  out  2  constant 2'b01 (INCR)
aw_oram_addr  out  ORAM_AW  ORAM address of the burst's first beat
w_vld  out  1  data beat valid
w_rdy  in  1  data beat accept
w_data  out  DATA_W  beat data
w_strb  out  DATA_W/8  all ones
w_last  out  1  high on the final beat of each burst
b_vld  in  1  write response valid
b_rdy  out  1  constant 1
b_resp  in  2  AXI response code
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a command completes
err  out  1  sticky: set by any b_resp other than 2'b00; cleared on command accept
outstanding  out  5  count of AW handshakes awaiting a B response

Behaviour:
- Reset values: state IDLE; cmd_rdy=1; all valids, oram_rd_en, done, err, outstanding and counters = 0.
- Command latch: on cmd_vld & cmd_rdy, latch all cmd_* fields, clear err, set burst counter bcnt=0, move to ADDR.
- cmd_rdy: equals (state==IDLE).
- ADDR state:
  - aw_vld=1 while outstanding < MAX_OUT.
  - On aw_vld & aw_rdy: move to DATA and set beat counter wcnt=0.
  - aw_addr = cmd_addr + bcnt*stride.
  - aw_oram_addr = cmd_oram_addr + bcnt*(cmd_len+1).
  - All AW fields hold stable while aw_vld=1.
- DATA state:
  - oram_rd_en=1 when fewer than cmd_len+1 beats of this burst have been read and the skid buffer has room for the returning word (occupancy + reads in flight < 2).
  - oram_rd_addr = the running ORAM pointer, incremented per read; it continues across burst boundaries.
  - Returned data is pushed into the skid buffer. w_vld = buffer not empty; w_data = buffer head.
  - On w_vld & w_rdy: pop the buffer and increment wcnt. w_last = (wcnt == cmd_len).
  - On the last-beat handshake: if bcnt==cmd_num, go to WAIT_B; otherwise increment bcnt and go to ADDR.
  - Throughput: 1 beat/cycle with w_rdy held high, after 1 cycle of ORAM latency.
- WAIT_B state: stay until outstanding==0, then go to DONE.
- DONE state: done=1 for exactly one cycle, then IDLE.
- outstanding counter:
  - +1 on AW handshake, -1 on B handshake (b_vld, since b_rdy=1); both in the same cycle leaves it unchanged.
  - B responses are accepted in every state.
  - b_vld with outstanding==0 is a protocol error: ignored, counter saturates at 0.
- Wrap-around: address and ORAM pointer arithmetic wraps silently; no split at 2^ADDR_W.
- Reset mid-operation: all state returns to reset values immediately; in-flight AXI transactions are abandoned (the system resets the write interface on the same rst_n).

Decomposition:
- Shared package: stride encoding constants and the stride-to-bytes function; FSM state encoding (IDLE, ADDR, DATA, WAIT_B, DONE); AXI constants SIZE_8B=3'b011, BURST_INCR=2'b01, RESP_OKAY=2'b00.
- One sub-module: wr_skid_fifo, a 2-entry, DATA_W-wide FIFO with push, pop, empty and count outputs; reset empty.

Test Plan:
- Single burst: cmd addr=0x040, num=0, len=3, oram=0x100, aw_rdy=w_rdy=1 -> one AW with addr 0x040, len 3; 4 beats from ORAM 0x100-0x103; w_last on beat 4; done one cycle after the B response.
- Strided: num=2, stride=1, addr=0x3F0, len=0 -> AW addresses 0x3F0, 0x010 (wrapped), 0x030; aw_oram_addr 0x100, 0x101, 0x102.
- Backpressure: w_rdy toggling 1/0 -> no beat lost or duplicated; w_data sequence matches ORAM order; never more than 2 reads ahead of the last accepted beat.
- Outstanding limit: MAX_OUT=2, num=3, B responses withheld -> aw_vld drops after 2 AW handshakes, outstanding=2; releasing one B lets the next AW issue.
- Error: the second B response has b_resp=2'b10 -> err=1 stays through DONE and clears on the next command accept.
- Reset: assert rst_n low during DATA -> all outputs return to reset values in the same cycle; a following command runs correctly.

Source files
------------

// File: rtl/lsu_axi_wr_sched_pkg.sv
// Shared encodings for the LSU strided store sequencer.
package lsu_axi_wr_sched_pkg;

   localparam int unsigned ST_W = 3;

   // FSM state encoding
   localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [ST_W-1:0] ST_ADDR   = 3'd1;
   localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
   localparam logic [ST_W-1:0] ST_WAIT_B = 3'd3;
   localparam logic [ST_W-1:0] ST_DONE   = 3'd4;

   // Burst-to-burst stride encoding
   localparam logic [2:0] STRIDE_16  = 3'd0;
   localparam logic [2:0] STRIDE_32  = 3'd1;
   localparam logic [2:0] STRIDE_64  = 3'd2;
   localparam logic [2:0] STRIDE_128 = 3'd3;
   localparam logic [2:0] STRIDE_256 = 3'd4;

   // AXI constants
   localparam logic [2:0] SIZE_8B    = 3'b011;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   // Stride code to byte step; reserved codes fall back to 16 bytes
   function automatic logic [8:0] stride_bytes(input logic [2:0] enc);
      case (enc)
         STRIDE_16:  return 9'd16;
         STRIDE_32:  return 9'd32;
         STRIDE_64:  return 9'd64;
         STRIDE_128: return 9'd128;
         STRIDE_256: return 9'd256;
         default:    return 9'd16;
      endcase
   endfunction

endpackage

// File: rtl/wr_skid_fifo.sv
// Two-entry skid buffer between ORAM read data and the W channel.
module wr_skid_fifo #(
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem_q [2];
   logic [DATA_W-1:0] mem_d [2];
   logic              wr_q, wr_d;
   logic              rd_q, rd_d;
   logic [1:0]        cnt_q, cnt_d;

   // Next-state: write at wr pointer, advance pointers, track occupancy
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q + 2'(push) - 2'(pop);
      if (push) begin
         mem_d[wr_q] = din;
         wr_d        = ~wr_q;
      end
      if (pop) begin
         rd_d = ~rd_q;
      end
   end

   // Storage and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign dout  = mem_q[rd_q];
   assign empty = (cnt_q == 2'd0);
   assign count = cnt_q;

endmodule

// File: rtl/lsu_axi_wr_sched.sv
// Splits one strided store command into INCR bursts, streams ORAM beats
// onto the AXI write channels and tracks outstanding B responses.
module lsu_axi_wr_sched
   import lsu_axi_wr_sched_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned ORAM_AW = 12,
   parameter int unsigned MAX_OUT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_vld,
   output logic                 cmd_rdy,
   input  logic [ADDR_W-1:0]    cmd_addr,
   input  logic [2:0]           cmd_stride,
   input  logic [3:0]           cmd_num,
   input  logic [7:0]           cmd_len,
   input  logic [ORAM_AW-1:0]   cmd_oram_addr,
   output logic                 oram_rd_en,
   output logic [ORAM_AW-1:0]   oram_rd_addr,
   input  logic [DATA_W-1:0]    oram_rd_data,
   output logic                 aw_vld,
   input  logic                 aw_rdy,
   output logic [ADDR_W-1:0]    aw_addr,
   output logic [7:0]           aw_len,
   output logic [2:0]           aw_size,
   output logic [1:0]           aw_burst,
   output logic [ORAM_AW-1:0]   aw_oram_addr,
   output logic                 w_vld,
   input  logic                 w_rdy,
   output logic [DATA_W-1:0]    w_data,
   output logic [DATA_W/8-1:0]  w_strb,
   output logic                 w_last,
   input  logic                 b_vld,
   output logic                 b_rdy,
   input  logic [1:0]           b_resp,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [4:0]           outstanding
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OUT_W  = 5;
   localparam int unsigned RCNT_W = 9;
   localparam int unsigned OFF_W  = 13;

   logic [ST_W-1:0]    state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [2:0]         stride_q, stride_d;
   logic [3:0]         num_q, num_d;
   logic [7:0]         len_q, len_d;
   logic [ORAM_AW-1:0] oram_q, oram_d;
   logic [3:0]         bcnt_q, bcnt_d;
   logic [7:0]         wcnt_q, wcnt_d;
   logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
   logic [ORAM_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic               rd_pend_q, rd_pend_d;
   logic [OUT_W-1:0]   out_q, out_d;
   logic               err_q, err_d;

   logic               aw_hs, w_hs, b_hs;
   logic               fifo_empty;
   logic [1:0]         fifo_cnt;
   logic [1:0]         fifo_load;
   logic [OFF_W-1:0]   stride_off, oram_off;

   wr_skid_fifo #(.DATA_W(DATA_W)) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rd_pend_q),
      .din   (oram_rd_data),
      .pop   (w_hs),
      .dout  (w_data),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );

   // Burst address offsets derived from the burst index
   always_comb begin
      stride_off = OFF_W'(bcnt_q) * OFF_W'(stride_bytes(stride_q));
      oram_off   = OFF_W'(bcnt_q) * OFF_W'({1'b0, len_q} + 9'd1);
   end

   assign aw_hs = aw_vld & aw_rdy;
   assign w_hs  = w_vld & w_rdy;
   assign b_hs  = b_vld & (out_q != '0);

   // Buffer load after this cycle's pop plus the word still coming from ORAM
   assign fifo_load  = fifo_cnt - 2'(w_hs) + 2'(rd_pend_q);
   assign oram_rd_en = (state_q == ST_DATA) && (rcnt_q <= {1'b0, len_q}) &&
                       (fifo_load < 2'd2);

   // Next-state and datapath updates
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      stride_d  = stride_q;
      num_d     = num_q;
      len_d     = len_q;
      oram_d    = oram_q;
      bcnt_d    = bcnt_q;
      wcnt_d    = wcnt_q;
      rcnt_d    = rcnt_q;
      rd_ptr_d  = rd_ptr_q;
      rd_pend_d = oram_rd_en;
      out_d     = out_q;
      err_d     = err_q;

      case ({aw_hs, b_hs})
         2'b10:   out_d = out_q + OUT_W'(1);
         2'b01:   out_d = out_q - OUT_W'(1);
         default: out_d = out_q;
      endcase

      if (b_hs && (b_resp != RESP_OKAY)) err_d = 1'b1;

      if (oram_rd_en) begin
         rd_ptr_d = rd_ptr_q + ORAM_AW'(1);
         rcnt_d   = rcnt_q + RCNT_W'(1);
      end

      if (w_hs) wcnt_d = wcnt_q + 8'd1;

      case (state_q)
         ST_IDLE: begin
            if (cmd_vld) begin
               addr_d   = cmd_addr;
               stride_d = cmd_stride;
               num_d    = cmd_num;
               len_d    = cmd_len;
               oram_d   = cmd_oram_addr;
               rd_ptr_d = cmd_oram_addr;
               bcnt_d   = 4'd0;
               err_d    = 1'b0;
               state_d  = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (aw_hs) begin
               wcnt_d  = 8'd0;
               rcnt_d  = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_hs && (wcnt_q == len_q)) begin
               if (bcnt_q == num_q) begin
                  state_d = ST_WAIT_B;
               end else begin
                  bcnt_d  = bcnt_q + 4'd1;
                  state_d = ST_ADDR;
               end
            end
         end
         ST_WAIT_B: begin
            if (out_d == '0) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         stride_q  <= 3'd0;
         num_q     <= 4'd0;
         len_q     <= 8'd0;
         oram_q    <= '0;
         bcnt_q    <= 4'd0;
         wcnt_q    <= 8'd0;
         rcnt_q    <= '0;
         rd_ptr_q  <= '0;
         rd_pend_q <= 1'b0;
         out_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         stride_q  <= stride_d;
         num_q     <= num_d;
         len_q     <= len_d;
         oram_q    <= oram_d;
         bcnt_q    <= bcnt_d;
         wcnt_q    <= wcnt_d;
         rcnt_q    <= rcnt_d;
         rd_ptr_q  <= rd_ptr_d;
         rd_pend_q <= rd_pend_d;
         out_q     <= out_d;
         err_q     <= err_d;
      end
   end

   assign cmd_rdy      = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DONE);
   assign err          = err_q;
   assign outstanding  = out_q;
   assign aw_vld       = (state_q == ST_ADDR) && (out_q < OUT_W'(MAX_OUT));
   assign aw_addr      = addr_q + ADDR_W'(stride_off);
   assign aw_oram_addr = oram_q + ORAM_AW'(oram_off);
   assign aw_len       = len_q;
   assign aw_size      = SIZE_8B;
   assign aw_burst     = BURST_INCR;
   assign oram_rd_addr = rd_ptr_q;
   assign w_vld        = ~fifo_empty;
   assign w_last       = w_vld && (wcnt_q == len_q);
   assign w_strb       = {STRB_W{1'b1}};
   assign b_rdy        = 1'b1;

endmodule
